// File: rtl/cmd_frame_rx_pkg.sv
// Shared types and constants for the UART command frame receiver.
// Holds the FSM state encodings, abort cause codes and the default sync marker.
package cmd_frame_rx_pkg;

  typedef enum logic [2:0] {
    S_HUNT,
    S_ACK,
    S_ADDR,
    S_DATA,
    S_CSUM,
    S_DONE
  } frame_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_BITS,
    RX_STOP
  } rx_state_e;

  localparam logic [1:0] ERR_CSUM     = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
  localparam logic [1:0] ERR_LINE     = 2'd3;
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cmd_frame_rx_rx.sv
// UART byte receiver (8N1, LSB first). A good byte raises rx_avail until rx_ack;
// a low stop bit produces a 1-cycle rx_err instead of a byte.
module cmd_frame_rx_rx
  import cmd_frame_rx_pkg::*;
#(
  parameter int BAUD_DIV = 128
) (
  input  logic       i_clk,
  input  logic       rst,
  input  logic       uart_rx,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_avail,
  output logic       rx_err
);

  localparam int BW = $clog2(BAUD_DIV);

  rx_state_e   st_q, st_d;
  logic [1:0]  sync_q, sync_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        avail_q, avail_d;
  logic        err_q, err_d;
  logic        rxs;

  assign rxs = sync_q[1];

  always_comb begin
    st_d    = st_q;
    sync_d  = {sync_q[0], uart_rx};
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    avail_d = avail_q & ~rx_ack;
    err_d   = 1'b0;
    case (st_q)
      RX_IDLE: begin
        if (!rxs) begin
          st_d   = RX_START;
          baud_d = BW'(BAUD_DIV / 2 - 1);
        end
      end
      RX_START: begin
        // Re-check at mid start bit so a glitch does not start a byte.
        if (baud_q == '0) begin
          if (!rxs) begin
            st_d   = RX_BITS;
            baud_d = BW'(BAUD_DIV - 1);
            bit_d  = 3'd0;
          end else begin
            st_d = RX_IDLE;
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      RX_BITS: begin
        if (baud_q == '0) begin
          shift_d = {rxs, shift_q[7:1]};
          baud_d  = BW'(BAUD_DIV - 1);
          if (bit_q == 3'd7) st_d = RX_STOP;
          else               bit_d = bit_q + 1'b1;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      RX_STOP: begin
        if (baud_q == '0) begin
          st_d = RX_IDLE;
          if (rxs) begin
            data_d  = shift_q;
            avail_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      default: st_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!rst) begin
      st_q    <= RX_IDLE;
      sync_q  <= 2'b11;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      avail_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      st_q    <= st_d;
      sync_q  <= sync_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      avail_q <= avail_d;
      err_q   <= err_d;
    end
  end

  assign rx_data  = data_q;
  assign rx_avail = avail_q;
  assign rx_err   = err_q;

endmodule

// File: rtl/cmd_frame_rx.sv
// Frame receiver: sync hunt, address/data collection, optional checksum, and
// timeout / line error aborts, presenting one command strobe per good frame.
//   state  | meaning
//   HUNT   | idle, dropping bytes until the sync marker
//   ACK    | acknowledge the byte just taken, then go to ret_q
//   ADDR   | collecting address bytes, MSB first
//   DATA   | collecting data bytes, LSB first
//   CSUM   | waiting for the checksum byte
//   DONE   | command or checksum error presented this cycle
module cmd_frame_rx
  import cmd_frame_rx_pkg::*;
#(
  parameter int         BAUD_DIV    = 128,
  parameter int         ADDR_BYTES  = 1,
  parameter int         DATA_BYTES  = 2,
  parameter logic [7:0] SYNC_BYTE   = SYNC_DEFAULT,
  parameter int         USE_CSUM    = 1,
  parameter int         TIMEOUT_CYC = 65536
) (
  input  logic                    i_clk,
  input  logic                    rst,
  input  logic                    uart_rx,
  output logic                    cmd_en,
  output logic [8*ADDR_BYTES-1:0] cmd_addr,
  output logic [8*DATA_BYTES-1:0] cmd_data,
  output logic                    cmd_err,
  output logic [1:0]              err_code,
  output logic                    busy
);

  localparam int AW = 8 * ADDR_BYTES;
  localparam int DW = 8 * DATA_BYTES;
  localparam int CW = $clog2(max_int(ADDR_BYTES, DATA_BYTES) + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [7:0] rx_data;
  logic       rx_avail, rx_err, rx_ack;

  cmd_frame_rx_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .i_clk    (i_clk),
    .rst      (rst),
    .uart_rx  (uart_rx),
    .rx_ack   (rx_ack),
    .rx_data  (rx_data),
    .rx_avail (rx_avail),
    .rx_err   (rx_err)
  );

  frame_state_e  st_q, st_d, ret_q, ret_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    sum_q, sum_d, csum_total;
  logic [AW-1:0] addr_sh_q, addr_sh_d, cmd_addr_q, cmd_addr_d;
  logic [DW-1:0] data_sh_q, data_sh_d, cmd_data_q, cmd_data_d;
  logic          csum_bad_q, csum_bad_d;
  logic          busy_q, busy_d;
  logic          cmd_en_q, cmd_en_d, cmd_err_q, cmd_err_d;
  logic [1:0]    err_code_q, err_code_d;

  assign rx_ack     = (st_q == S_ACK);
  assign csum_total = sum_q + rx_data;

  always_comb begin
    st_d       = st_q;
    ret_d      = ret_q;
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
    sum_d      = sum_q;
    addr_sh_d  = addr_sh_q;
    data_sh_d  = data_sh_q;
    csum_bad_d = csum_bad_q;
    busy_d     = busy_q;
    cmd_en_d   = 1'b0;
    cmd_err_d  = 1'b0;
    err_code_d = err_code_q;
    cmd_addr_d = cmd_addr_q;
    cmd_data_d = cmd_data_q;
    case (st_q)
      S_HUNT: begin
        if (rx_avail) begin
          st_d  = S_ACK;
          ret_d = S_HUNT;
          if (rx_data == SYNC_BYTE) begin
            ret_d      = S_ADDR;
            busy_d     = 1'b1;
            cnt_d      = '0;
            tmo_d      = '0;
            sum_d      = '0;
            csum_bad_d = 1'b0;
          end
        end
      end
      S_ADDR, S_DATA, S_CSUM: begin
        // Line errors win over a simultaneous timeout; any pending byte is still acked.
        if (rx_err || (!rx_avail && tmo_q == TW'(TIMEOUT_CYC - 1))) begin
          cmd_err_d  = 1'b1;
          err_code_d = rx_err ? ERR_LINE : ERR_TIMEOUT;
          busy_d     = 1'b0;
          ret_d      = S_HUNT;
          st_d       = rx_avail ? S_ACK : S_HUNT;
        end else if (rx_avail) begin
          st_d  = S_ACK;
          tmo_d = '0;
          if (st_q == S_ADDR) begin
            sum_d = csum_total;
            for (int i = 0; i < ADDR_BYTES; i++)
              if (cnt_q == CW'(ADDR_BYTES - 1 - i)) addr_sh_d[8*i +: 8] = rx_data;
            if (cnt_q == CW'(ADDR_BYTES - 1)) begin
              cnt_d = '0;
              ret_d = S_DATA;
            end else begin
              cnt_d = cnt_q + 1'b1;
              ret_d = S_ADDR;
            end
          end else if (st_q == S_DATA) begin
            sum_d = csum_total;
            for (int i = 0; i < DATA_BYTES; i++)
              if (cnt_q == CW'(i)) data_sh_d[8*i +: 8] = rx_data;
            if (cnt_q == CW'(DATA_BYTES - 1)) begin
              cnt_d = '0;
              ret_d = (USE_CSUM != 0) ? S_CSUM : S_DONE;
            end else begin
              cnt_d = cnt_q + 1'b1;
              ret_d = S_DATA;
            end
          end else begin
            csum_bad_d = (csum_total != 8'h00);
            ret_d      = S_DONE;
          end
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_ACK: begin
        st_d = ret_q;
        // Registering the result here puts cmd_en/cmd_err and busy=0 in the DONE cycle.
        if (ret_q == S_DONE) begin
          busy_d = 1'b0;
          if (csum_bad_q) begin
            cmd_err_d  = 1'b1;
            err_code_d = ERR_CSUM;
          end else begin
            cmd_en_d   = 1'b1;
            cmd_addr_d = addr_sh_q;
            cmd_data_d = data_sh_q;
          end
        end
      end
      S_DONE:  st_d = S_HUNT;
      default: st_d = S_HUNT;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!rst) begin
      st_q       <= S_HUNT;
      ret_q      <= S_HUNT;
      cnt_q      <= '0;
      tmo_q      <= '0;
      sum_q      <= '0;
      addr_sh_q  <= '0;
      data_sh_q  <= '0;
      csum_bad_q <= 1'b0;
      busy_q     <= 1'b0;
      cmd_en_q   <= 1'b0;
      cmd_err_q  <= 1'b0;
      err_code_q <= '0;
      cmd_addr_q <= '0;
      cmd_data_q <= '0;
    end else begin
      st_q       <= st_d;
      ret_q      <= ret_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      sum_q      <= sum_d;
      addr_sh_q  <= addr_sh_d;
      data_sh_q  <= data_sh_d;
      csum_bad_q <= csum_bad_d;
      busy_q     <= busy_d;
      cmd_en_q   <= cmd_en_d;
      cmd_err_q  <= cmd_err_d;
      err_code_q <= err_code_d;
      cmd_addr_q <= cmd_addr_d;
      cmd_data_q <= cmd_data_d;
    end
  end

  assign cmd_en   = cmd_en_q;
  assign cmd_err  = cmd_err_q;
  assign err_code = err_code_q;
  assign cmd_addr = cmd_addr_q;
  assign cmd_data = cmd_data_q;
  assign busy     = busy_q;

endmodule
